data_mem_mmio: RTL and testbench



---
 rtl/data_mem_mmio_if.sv | 25 ++
 rtl/data_mem_mmio.sv | 179 +++++++++++++++++
 tb/tb_data_mem_mmio.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_mmio_if
//  Description : Core data-port bundle between load/store stage and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_mmio_if;
   logic [31:0] i_addr;
   logic [31:0] i_write_data;
   logic        i_read_en;
   logic        i_write_en;
   logic [31:0] o_read_data;
   logic        o_bus_err;

   modport master (
      output i_addr, i_write_data, i_read_en, i_write_en,
      input  o_read_data, o_bus_err
   );

   modport slave (
      input  i_addr, i_write_data, i_read_en, i_write_en,
      output o_read_data, o_bus_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_mmio
//  Description : Data-side word RAM plus MMIO timer/compare-IRQ and UART TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_mmio #(
   parameter int unsigned RAM_WORDS    = 1024,
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           rstn,
   data_mem_mmio_if.slave bus,
   output logic           o_timer_irq,
   output logic           o_uart_tx
);

   localparam int unsigned c_aw     = $clog2(RAM_WORDS);
   localparam int unsigned c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

   localparam logic [1:0] c_off_count   = 2'd0;
   localparam logic [1:0] c_off_compare = 2'd1;
   localparam logic [1:0] c_off_status  = 2'd2;
   localparam logic [1:0] c_off_txdata  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   // ---------------------------------------------------------------- decode
   logic                w_ram_hit;
   logic                w_mmio_hit;
   logic                w_unmapped;
   logic [c_aw-1:0]     w_ram_idx;
   logic [1:0]          w_off;
   logic                w_wr_mmio;
   logic                w_wr_count;
   logic                w_wr_compare;
   logic                w_wr_status;
   logic                w_wr_txdata;
   logic                w_uart_busy;
   logic [31:0]         w_mmio_rdata;

   assign w_ram_hit    = ((bus.i_addr >> (c_aw + 2)) == 32'd0);
   assign w_mmio_hit   = (bus.i_addr[31:4] == MMIO_BASE[31:4]);
   assign w_unmapped   = !w_ram_hit && !w_mmio_hit;
   assign w_ram_idx    = bus.i_addr[c_aw+1:2];
   assign w_off        = bus.i_addr[3:2];
   assign w_wr_mmio    = bus.i_write_en && w_mmio_hit;
   assign w_wr_count   = w_wr_mmio && (w_off == c_off_count);
   assign w_wr_compare = w_wr_mmio && (w_off == c_off_compare);
   assign w_wr_status  = w_wr_mmio && (w_off == c_off_status);
   assign w_wr_txdata  = w_wr_mmio && (w_off == c_off_txdata);

   // ------------------------------------------------------------------- RAM
   logic [31:0] ram_q [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (bus.i_write_en && w_ram_hit) begin
         ram_q[w_ram_idx] <= bus.i_write_data;
      end
   end

   // ----------------------------------------------------------------- timer
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        match_q, match_d;
   logic        bus_err_q;

   always_comb begin
      count_d   = w_wr_count   ? bus.i_write_data : count_q + 32'd1;
      compare_d = w_wr_compare ? bus.i_write_data : compare_q;
      // Setting takes priority over a W1C clear landing in the same cycle.
      match_d   = (count_q == compare_q) ||
                  (match_q && !(w_wr_status && bus.i_write_data[0]));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
         match_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         match_q   <= match_d;
         bus_err_q <= (bus.i_read_en || bus.i_write_en) && w_unmapped;
      end
   end

   // ------------------------------------------------------------------ UART
   uart_state_t         state_q;
   logic [c_baud_w-1:0] baud_q;
   logic [2:0]          bit_q;
   logic [7:0]          shift_q;
   logic                tx_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_wr_txdata) begin
                  shift_q <= bus.i_write_data[7:0];
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_q == c_baud_last) begin
                  baud_q  <= '0;
                  bit_q   <= 3'd0;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_q == c_baud_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= shift_q[bit_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_q == c_baud_last) begin
                  baud_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign w_uart_busy = (state_q != S_IDLE);

   // ------------------------------------------------------------- read path
   always_comb begin
      w_mmio_rdata = 32'd0;
      case (w_off)
         c_off_count:   w_mmio_rdata = count_q;
         c_off_compare: w_mmio_rdata = compare_q;
         c_off_status:  w_mmio_rdata = {30'd0, w_uart_busy, match_q};
         default:       w_mmio_rdata = 32'd0;
      endcase
   end

   assign bus.o_read_data = !bus.i_read_en ? 32'd0            :
                            w_ram_hit      ? ram_q[w_ram_idx] :
                            w_mmio_hit     ? w_mmio_rdata     : 32'd0;
   assign bus.o_bus_err   = bus_err_q;
   assign o_timer_irq     = match_q;
   assign o_uart_tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_mmio
//  Description : Self-checking bench for data_mem_mmio against a cycle-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_mmio;

   localparam int unsigned RW  = 64;
   localparam int unsigned CPB = 4;
   localparam logic [31:0] BASE      = 32'hFFFF_0000;
   localparam logic [31:0] A_COUNT   = BASE;
   localparam logic [31:0] A_COMPARE = BASE + 32'd4;
   localparam logic [31:0] A_STATUS  = BASE + 32'd8;
   localparam logic [31:0] A_TXDATA  = BASE + 32'd12;

   logic clk = 1'b0;
   logic rstn;
   logic o_timer_irq;
   logic o_uart_tx;

   data_mem_mmio_if bus ();

   data_mem_mmio #(
      .RAM_WORDS    (RW),
      .MMIO_BASE    (BASE),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus),
      .o_timer_irq (o_timer_irq),
      .o_uart_tx   (o_uart_tx)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   longint      cyc      = 0;
   logic [31:0] m_ram   [RW];
   bit          m_valid [RW];
   logic [31:0] m_cnt_base = 32'd0;
   longint      m_cnt_cyc  = 0;
   logic [31:0] m_cmp      = 32'hFFFF_FFFF;
   logic [7:0]  m_tx_byte  = 8'd0;
   longint      m_tx_start = -1000000;

   // Timer value is the last loaded value plus the edges seen since then.
   function automatic logic [31:0] exp_count();
      return m_cnt_base + 32'(cyc - m_cnt_cyc);
   endfunction

   function automatic bit exp_busy();
      return (cyc - m_tx_start) >= 0 && (cyc - m_tx_start) < longint'(10 * CPB);
   endfunction

   // Line level from position in the frame: start, 8 data bits LSB-first, stop.
   function automatic logic exp_tx();
      longint el;
      int     k;
      el = cyc - m_tx_start;
      if (el < 0 || el >= longint'(10 * CPB)) return 1'b1;
      k = int'(el) / int'(CPB);
      if (k == 0) return 1'b0;
      if (k <= 8) return m_tx_byte[k-1];
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d,
                        input logic re, input logic we);
      bus.i_addr       = a;
      bus.i_write_data = d;
      bus.i_read_en    = re;
      bus.i_write_en   = we;
      #1;
   endtask

   task automatic idle();
      bus.i_addr       = 32'd0;
      bus.i_write_data = 32'd0;
      bus.i_read_en    = 1'b0;
      bus.i_write_en   = 1'b0;
   endtask

   task automatic model_commit(input logic [31:0] a, input logic [31:0] d, input bit was_busy);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      if (a < 32'(4 * RW)) begin
         m_ram[int'(a >> 2)]   = d;
         m_valid[int'(a >> 2)] = 1'b1;
      end else if (wa == A_COUNT) begin
         m_cnt_base = d;
         m_cnt_cyc  = cyc;
      end else if (wa == A_COMPARE) begin
         m_cmp = d;
      end else if (wa == A_TXDATA && !was_busy) begin
         m_tx_byte  = d[7:0];
         m_tx_start = cyc;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bit busy;
      busy = exp_busy();
      drive(a, d, 1'b0, 1'b1);
      step();
      idle();
      model_commit(a, d, busy);
   endtask

   task automatic model_reset();
      m_cmp      = 32'hFFFF_FFFF;
      m_tx_start = -1000000;
      m_cnt_base = 32'd0;
      m_cnt_cyc  = cyc;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rstn = 1'b0;
      idle();
      repeat (3) step();
      checks++; if (o_uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", o_uart_tx); end
      checks++; if (o_timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", o_timer_irq); end
      checks++; if (bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b expected 0", bus.o_bus_err); end
      drive(A_COUNT, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL reset_count: got %h expected 0", bus.o_read_data); end
      drive(A_COMPARE, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_compare: got %h expected ffffffff", bus.o_read_data); end
      drive(A_STATUS, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL reset_status: got %h expected 0", bus.o_read_data); end
      rstn = 1'b1;
      model_reset();
      drive(A_COUNT, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== exp_count()) begin failures++; $display("FAIL count_release: got %h expected %h", bus.o_read_data, exp_count()); end
      step();
      checks++; if (bus.o_read_data !== exp_count()) begin failures++; $display("FAIL count_first_inc: got %h expected %h", bus.o_read_data, exp_count()); end
      idle();
   endtask

   task automatic test_ram();
      logic [31:0] a, d;
      int          idx, op;
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      drive(32'h0000_0013, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read: got %h expected deadbeef", bus.o_read_data); end
      drive(32'h0000_0013, 32'd0, 1'b0, 1'b0);
      checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL ram_read_en_low: got %h expected 0", bus.o_read_data); end
      idle();
      for (int i = 0; i < 60; i++) begin
         idx = int'($urandom_range(0, RW - 1));
         a   = 32'(idx * 4) | 32'($urandom_range(0, 3));
         d   = $urandom;
         op  = int'($urandom_range(0, 2));
         if (!m_valid[idx]) op = 0;
         if (op == 0) begin
            wr(a, d);
         end else begin
            drive(a, d, 1'b1, op == 2);
            checks++; if (bus.o_read_data !== m_ram[idx]) begin failures++; $display("FAIL ram_rand_read[%0d]: got %h expected %h", idx, bus.o_read_data, m_ram[idx]); end
            step();
            idle();
            if (op == 2) model_commit(a, d, 1'b0);
         end
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] list [6];
      logic [31:0] a;
      list[0] = 32'(4 * RW);
      list[1] = BASE + 32'd16;
      list[2] = BASE - 32'd4;
      list[3] = 32'hFFFF_FFFC;
      list[4] = $urandom_range(32'h0000_1000, 32'h7FFF_FFFF);
      list[5] = 32'h8000_0000 | 32'($urandom_range(0, 32'h7FFE_FFFF));
      wr(32'd0, 32'h1234_5678);
      drive(32'h8000_0000, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL unmapped_read: got %h expected 0", bus.o_read_data); end
      step();
      idle();
      checks++; if (bus.o_bus_err !== 1'b1) begin failures++; $display("FAIL bus_err_pulse: got %b expected 1", bus.o_bus_err); end
      step();
      checks++; if (bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL bus_err_one_cycle: got %b expected 0", bus.o_bus_err); end
      wr(32'h8000_0000, 32'hCAFE_F00D);
      checks++; if (bus.o_bus_err !== 1'b1) begin failures++; $display("FAIL bus_err_write: got %b expected 1", bus.o_bus_err); end
      drive(32'd0, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== m_ram[0]) begin failures++; $display("FAIL unmapped_ram_intact: got %h expected %h", bus.o_read_data, m_ram[0]); end
      drive(A_COMPARE, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== m_cmp) begin failures++; $display("FAIL unmapped_mmio_intact: got %h expected %h", bus.o_read_data, m_cmp); end
      drive(A_COUNT, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== exp_count()) begin failures++; $display("FAIL unmapped_count_intact: got %h expected %h", bus.o_read_data, exp_count()); end
      step();
      idle();
      for (int i = 0; i < 6; i++) begin
         a = list[i];
         if (i[0]) wr(a, $urandom);
         else begin
            drive(a, 32'd0, 1'b1, 1'b0);
            checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL unmapped_read[%0d]: got %h expected 0", i, bus.o_read_data); end
            step();
            idle();
         end
         checks++; if (bus.o_bus_err !== 1'b1) begin failures++; $display("FAIL bus_err_addr[%0d] %h: got %b expected 1", i, a, bus.o_bus_err); end
      end
      drive(32'h8000_0000, 32'd0, 1'b0, 1'b0);
      step();
      checks++; if (bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL bus_err_no_enable: got %b expected 0", bus.o_bus_err); end
      idle();
   endtask

   task automatic test_timer();
      wr(A_COMPARE, 32'd10);
      wr(A_COUNT, 32'd5);
      for (int i = 1; i <= 6; i++) begin
         step();
         checks++; if (o_timer_irq !== (i == 6)) begin failures++; $display("FAIL irq_rise[%0d]: got %b expected %b", i, o_timer_irq, i == 6); end
      end
      drive(A_STATUS, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data[0] !== 1'b1) begin failures++; $display("FAIL status_match: got %b expected 1", bus.o_read_data[0]); end
      step();
      idle();
      wr(A_STATUS, 32'd1);
      checks++; if (o_timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b expected 0", o_timer_irq); end
      wr(A_COMPARE, exp_count() + 32'd8);
      for (int i = 0; i < 20 && exp_count() != m_cmp; i++) step();
      checks++; if (o_timer_irq !== 1'b0) begin failures++; $display("FAIL irq_pre_collision: got %b expected 0", o_timer_irq); end
      wr(A_STATUS, 32'd1);
      checks++; if (o_timer_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins: got %b expected 1", o_timer_irq); end
      wr(A_STATUS, 32'd1);
      checks++; if (o_timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear2: got %b expected 0", o_timer_irq); end
      wr(A_COUNT, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         drive(A_COUNT, 32'd0, 1'b1, 1'b0);
         checks++; if (bus.o_read_data !== exp_count()) begin failures++; $display("FAIL count_wrap[%0d]: got %h expected %h", i, bus.o_read_data, exp_count()); end
         step();
         idle();
      end
   endtask

   task automatic check_frame(input string tag, input int len, input int late_idx);
      for (int i = 0; i < len; i++) begin
         checks++; if (o_uart_tx !== exp_tx()) begin failures++; $display("FAIL %s_tx[%0d]: got %b expected %b", tag, i, o_uart_tx, exp_tx()); end
         drive(A_STATUS, 32'd0, 1'b1, 1'b0);
         checks++; if (bus.o_read_data[1] !== exp_busy()) begin failures++; $display("FAIL %s_busy[%0d]: got %b expected %b", tag, i, bus.o_read_data[1], exp_busy()); end
         idle();
         if (i == late_idx) wr(A_TXDATA, 32'h0000_003C);
         else step();
      end
   endtask

   task automatic test_uart();
      wr(A_TXDATA, 32'h0000_00A5);
      check_frame("uart", 10 * CPB + 4, -1);
   endtask

   task automatic test_uart_busy_write();
      wr(A_TXDATA, 32'h0000_00A5);
      check_frame("uart_busy", 10 * CPB + 8, 3 * CPB + 1);
   endtask

   task automatic test_reset_mid_frame();
      wr(A_COMPARE, exp_count() + 32'd3);
      repeat (4) step();
      checks++; if (o_timer_irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %b expected 1", o_timer_irq); end
      wr(A_TXDATA, 32'($urandom_range(0, 255)));
      repeat (3 * CPB + 1) step();
      checks++; if (o_uart_tx !== exp_tx()) begin failures++; $display("FAIL pre_reset_tx: got %b expected %b", o_uart_tx, exp_tx()); end
      rstn = 1'b0;
      #1;
      checks++; if (o_uart_tx !== 1'b1) begin failures++; $display("FAIL async_tx: got %b expected 1", o_uart_tx); end
      checks++; if (o_timer_irq !== 1'b0) begin failures++; $display("FAIL async_irq: got %b expected 0", o_timer_irq); end
      drive(A_COUNT, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL async_count: got %h expected 0", bus.o_read_data); end
      drive(A_STATUS, 32'd0, 1'b1, 1'b0);
      checks++; if (bus.o_read_data !== 32'd0) begin failures++; $display("FAIL async_status: got %h expected 0", bus.o_read_data); end
      idle();
      repeat (2) step();
      checks++; if (o_uart_tx !== 1'b1) begin failures++; $display("FAIL held_reset_tx: got %b expected 1", o_uart_tx); end
      rstn = 1'b1;
      model_reset();
      wr(A_TXDATA, 32'($urandom_range(0, 255)));
      check_frame("post_reset", 10 * CPB + 2, -1);
   endtask

   task automatic test_random();
      logic [31:0] a, d, exp_rd;
      logic        re, we, chk, err;
      int          cls, idx;
      bit          busy;
      for (int i = 0; i < 150; i++) begin
         cls = int'($urandom_range(0, 3));
         d   = $urandom;
         re  = 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         chk = 1'b1;
         err = 1'b0;
         case (cls)
            0: begin
               idx = int'($urandom_range(0, RW - 1));
               a   = 32'(idx * 4) | 32'($urandom_range(0, 3));
               if (re && !m_valid[idx]) we = 1'b1;
               exp_rd = m_valid[idx] ? m_ram[idx] : 32'd0;
               chk    = m_valid[idx];
            end
            1: begin a = A_COUNT   | 32'($urandom_range(0, 3)); exp_rd = exp_count(); end
            2: begin a = A_COMPARE | 32'($urandom_range(0, 3)); exp_rd = m_cmp; end
            default: begin
               a      = $urandom_range(4 * RW, 32'hFFFE_FFFF);
               exp_rd = 32'd0;
               err    = re || we;
            end
         endcase
         if (!re) begin exp_rd = 32'd0; chk = 1'b1; end
         busy = exp_busy();
         drive(a, d, re, we);
         if (chk) begin
            checks++; if (bus.o_read_data !== exp_rd) begin failures++; $display("FAIL rand_read[%0d] %h: got %h expected %h", i, a, bus.o_read_data, exp_rd); end
         end
         step();
         idle();
         if (we) model_commit(a, d, busy);
         checks++; if (bus.o_bus_err !== err) begin failures++; $display("FAIL rand_bus_err[%0d] %h: got %b expected %b", i, a, bus.o_bus_err, err); end
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_unmapped();
      test_timer();
      test_uart();
      test_uart_busy_write();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
